// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: widths, reset constants, FSM codes, IF/ID bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package if_stage_pkg;

  localparam int          P_XLEN     = 32;
  localparam logic [31:0] P_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] P_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  // Fetch FSM encodings
  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_WAIT       = 2'd1;
  localparam logic [1:0] ST_REDIR_WAIT = 2'd2;

  typedef struct packed {
    logic [P_XLEN-1:0] pc;
    logic [P_XLEN-1:0] pc_plus4;
    logic [31:0]       inst;
    logic              valid;
  } if_id_t;

  // Clear the two low bits of a redirect target
  function automatic logic [P_XLEN-1:0] align4(input logic [P_XLEN-1:0] a);
    return {a[P_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with flush (bubble), load and implicit hold.
// Latency: one cycle from i_load to outputs.
// Backpressure: holds contents whenever neither i_load nor i_flush is asserted; flush wins over load.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INST = P_NOP_INST
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic [P_XLEN-1:0] i_pc,
  input  logic [31:0]       i_inst,
  output logic [P_XLEN-1:0] o_pc,
  output logic [P_XLEN-1:0] o_pc_plus4,
  output logic [31:0]       o_inst,
  output logic              o_valid
);

  if_id_t r_ifid;

  // Register update: reset to a bubble, flush inserts a bubble, load captures a fetched word
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ifid.pc       <= '0;
      r_ifid.pc_plus4 <= P_XLEN'(4);
      r_ifid.inst     <= NOP_INST;
      r_ifid.valid    <= 1'b0;
    end else if (i_flush) begin
      // pc fields are left alone; they carry no meaning while valid is low
      r_ifid.inst     <= NOP_INST;
      r_ifid.valid    <= 1'b0;
    end else if (i_load) begin
      r_ifid.pc       <= i_pc;
      r_ifid.pc_plus4 <= i_pc + P_XLEN'(4);
      r_ifid.inst     <= i_inst;
      r_ifid.valid    <= 1'b1;
    end
  end

  assign o_pc       = r_ifid.pc;
  assign o_pc_plus4 = r_ifid.pc_plus4;
  assign o_inst     = r_ifid.inst;
  assign o_valid    = r_ifid.valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, next-PC select, imem handshake, IF/ID register. Optional MISALIGN_CHECK_EN adds inst_misaligned.
// Latency: one cycle from accepted fetch (imem_req & imem_ready) to valid_id.
// Backpressure: imem_ready=0 holds imem_addr; Load_hazard holds PC and IF/ID; a redirect during a wait is deferred until the fetch completes.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int               XLEN     = P_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = P_RESET_PC,
  parameter logic [31:0]      NOP_INST = P_NOP_INST
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            Load_hazard,
  input  logic            Branch_hazard,
  input  logic [XLEN-1:0] branch_target_exe,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc_id,
  output logic [XLEN-1:0] pc_plus4_id,
  output logic [31:0]     inst_id,
  output logic            valid_id,
`ifdef MISALIGN_CHECK_EN
  output logic            inst_misaligned,
`endif
  output logic            flush_ex
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tgt;
  logic [1:0]      r_state;

  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_tgt_nxt;
  logic [1:0]      w_state_nxt;
  logic            w_id_load;
  logic            w_id_flush;
  logic            w_redir;
  logic [XLEN-1:0] w_redir_tgt;
  logic [XLEN-1:0] w_redir_pc;

  assign imem_req  = reset_n;
  assign imem_addr = r_pc;
  assign flush_ex  = Branch_hazard | Load_hazard;

  // Next-state and next-PC selection; branch beats load stall, and REDIR_WAIT ignores load stalls
  always_comb begin
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    w_state_nxt = r_state;
    w_id_load   = 1'b0;
    w_id_flush  = 1'b0;
    w_redir     = 1'b0;
    w_redir_tgt = branch_target_exe;

    case (r_state)
      ST_REDIR_WAIT: begin
        // ID already holds a bubble; keep it and keep the address until the old fetch retires
        if (Branch_hazard) begin
          w_tgt_nxt = branch_target_exe;
        end
        if (imem_ready) begin
          w_redir     = 1'b1;
          w_redir_tgt = Branch_hazard ? branch_target_exe : r_tgt;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        // RUN and WAIT share rules; any completed fetch or redirect returns to RUN
        if (Branch_hazard) begin
          w_id_flush = 1'b1;
          if (imem_ready) begin
            w_redir     = 1'b1;
            w_state_nxt = ST_RUN;
          end else begin
            w_tgt_nxt   = branch_target_exe;
            w_state_nxt = ST_REDIR_WAIT;
          end
        end else if (Load_hazard) begin
          // word fetched this cycle (if any) is discarded and re-fetched
          w_state_nxt = r_state;
        end else if (imem_ready) begin
          w_id_load   = 1'b1;
          w_pc_nxt    = r_pc + XLEN'(4);
          w_state_nxt = ST_RUN;
        end else begin
          w_id_flush  = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
    endcase

`ifdef MISALIGN_CHECK_EN
    w_redir_pc = align4(w_redir_tgt);
`else
    w_redir_pc = w_redir_tgt;
`endif
    if (w_redir) begin
      w_pc_nxt = w_redir_pc;
    end
  end

  // PC, pending redirect target and FSM state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
      r_state <= ST_RUN;
    end else begin
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
      r_state <= w_state_nxt;
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic r_misaligned;

  // Flag set by a redirect to an unaligned target, cleared by the next instruction that enters ID
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_misaligned <= 1'b0;
    end else if (w_redir) begin
      r_misaligned <= |w_redir_tgt[1:0];
    end else if (w_id_load) begin
      r_misaligned <= 1'b0;
    end
  end

  assign inst_misaligned = r_misaligned;
`endif

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_id_load),
    .i_flush    (w_id_flush),
    .i_pc       (r_pc),
    .i_inst     (imem_rdata),
    .o_pc       (pc_id),
    .o_pc_plus4 (pc_plus4_id),
    .o_inst     (inst_id),
    .o_valid    (valid_id)
  );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed steps, a cycle-level reference model and literal checkpoints.
// Latency: n/a.
// Backpressure: imem_ready driven directly by the stimulus.
`timescale 1ns/1ps
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        Load_hazard;
  logic        Branch_hazard;
  logic [31:0] branch_target_exe;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_id;
  logic [31:0] pc_plus4_id;
  logic [31:0] inst_id;
  logic        valid_id;
  logic        flush_ex;
`ifdef MISALIGN_CHECK_EN
  logic        inst_misaligned;
`endif

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  // Memory contents: each word is derived from its own address so mix-ups are visible
  function automatic logic [31:0] mw(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[15:0]};
  endfunction

  assign imem_rdata = mw(imem_addr);

  if_stage dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .Load_hazard       (Load_hazard),
    .Branch_hazard     (Branch_hazard),
    .branch_target_exe (branch_target_exe),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .imem_rdata        (imem_rdata),
    .pc_id             (pc_id),
    .pc_plus4_id       (pc_plus4_id),
    .inst_id           (inst_id),
    .valid_id          (valid_id),
`ifdef MISALIGN_CHECK_EN
    .inst_misaligned   (inst_misaligned),
`endif
    .flush_ex          (flush_ex)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Architectural view: the PC being fetched, an optional deferred redirect, and what ID holds.
  logic [31:0] m_pc, m_tgt, m_id_pc, m_id_inst;
  bit          m_pend, m_id_valid, m_mis;

  function automatic logic [31:0] eff_tgt(input logic [31:0] t);
`ifdef MISALIGN_CHECK_EN
    return t & ~32'd3;
`else
    return t;
`endif
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_pc = 32'h0; m_tgt = 32'h0; m_pend = 0;
      m_id_pc = 32'h0; m_id_inst = 32'h13; m_id_valid = 0; m_mis = 0;
    end else if (m_pend) begin
      if (Branch_hazard) m_tgt = branch_target_exe;
      if (imem_ready) begin
        m_pc = eff_tgt(m_tgt); m_mis = (m_tgt[1:0] != 2'b00); m_pend = 0;
      end
    end else if (Branch_hazard) begin
      m_id_valid = 0; m_id_inst = 32'h13;
      if (imem_ready) begin
        m_pc = eff_tgt(branch_target_exe); m_mis = (branch_target_exe[1:0] != 2'b00);
      end else begin
        m_tgt = branch_target_exe; m_pend = 1;
      end
    end else if (Load_hazard) begin
      // nothing moves
    end else if (imem_ready) begin
      m_id_pc = m_pc; m_id_inst = mw(m_pc); m_id_valid = 1; m_mis = 0;
      m_pc = m_pc + 32'd4;
    end else begin
      m_id_valid = 0; m_id_inst = 32'h13;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      chk("imem_req", {31'b0, imem_req}, {31'b0, reset_n});
      chk("flush_ex", {31'b0, flush_ex}, {31'b0, Load_hazard | Branch_hazard});
      if (reset_n) chk("imem_addr", imem_addr, m_pc);
      chk("valid_id", {31'b0, valid_id}, {31'b0, m_id_valid});
      chk("inst_id", inst_id, m_id_inst);
      if (m_id_valid) begin
        chk("pc_id", pc_id, m_id_pc);
        chk("pc_plus4_id", pc_plus4_id, m_id_pc + 32'd4);
      end
`ifdef MISALIGN_CHECK_EN
      chk("inst_misaligned", {31'b0, inst_misaligned}, {31'b0, m_mis});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit rst_n, input bit ld, input bit br,
                      input logic [31:0] tgt, input bit rdy);
    reset_n           = rst_n;
    Load_hazard       = ld;
    Branch_hazard     = br;
    branch_target_exe = tgt;
    imem_ready        = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 0; Load_hazard = 0; Branch_hazard = 0;
    branch_target_exe = 32'h0; imem_ready = 0;

    step(0, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    armed = 1'b1;
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, valid_id}, 32'h0);
    chk("rst_inst", inst_id, 32'h0000_0013);
    chk("rst_pc_id", pc_id, 32'h0);

    // Steady fetch: 0,4,8,...
    step(1, 0, 0, 32'h0, 1);
    chk("s1_addr", imem_addr, 32'h4);
    chk("s1_valid", {31'b0, valid_id}, 32'h1);
    chk("s1_pc_id", pc_id, 32'h0);
    chk("s1_inst", inst_id, 32'hC3A5_0000);
    step(1, 0, 0, 32'h0, 1);
    chk("s2_addr", imem_addr, 32'h8);
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    chk("s4_addr", imem_addr, 32'h10);
    chk("s4_pc_id", pc_id, 32'hC);

    // Two-cycle load stall at pc 0x10
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0, 32'h0, 1);
      chk("ld_addr", imem_addr, 32'h10);
      chk("ld_pc_id", pc_id, 32'hC);
    end
    step(1, 0, 0, 32'h0, 1);
    chk("ld_resume_pc_id", pc_id, 32'h10);
    chk("ld_resume_addr", imem_addr, 32'h14);

    // Redirect with ready at pc 0x20
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    chk("pre_br_addr", imem_addr, 32'h20);
    step(1, 0, 1, 32'h100, 1);
    chk("br_addr", imem_addr, 32'h100);
    chk("br_valid", {31'b0, valid_id}, 32'h0);
    step(1, 0, 0, 32'h0, 1);
    chk("br_pc_id", pc_id, 32'h100);
    chk("br_valid2", {31'b0, valid_id}, 32'h1);

    // Three not-ready cycles, branch to 0x200 in the second
    step(1, 0, 0, 32'h0, 0);
    chk("w1_addr", imem_addr, 32'h104);
    step(1, 0, 1, 32'h200, 0);
    chk("w2_addr", imem_addr, 32'h104);
    step(1, 0, 0, 32'h0, 0);
    chk("w3_addr", imem_addr, 32'h104);
    step(1, 0, 0, 32'h0, 1);
    chk("w_done_addr", imem_addr, 32'h200);
    chk("w_done_valid", {31'b0, valid_id}, 32'h0);
    step(1, 0, 0, 32'h0, 1);
    chk("w_pc_id", pc_id, 32'h200);

    // Newest redirect wins during a wait; load stall is ignored there
    step(1, 0, 0, 32'h0, 0);
    step(1, 0, 1, 32'h300, 0);
    step(1, 0, 1, 32'h400, 0);
    step(1, 1, 0, 32'h0, 1);
    chk("newest_addr", imem_addr, 32'h400);

    // pc+4 wraps
    step(1, 0, 1, 32'hFFFF_FFFC, 1);
    step(1, 0, 0, 32'h0, 1);
    chk("wrap_pc_id", pc_id, 32'hFFFF_FFFC);
    chk("wrap_plus4", pc_plus4_id, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    // Unaligned redirect target
    step(1, 0, 1, 32'h102, 1);
`ifdef MISALIGN_CHECK_EN
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_flag", {31'b0, inst_misaligned}, 32'h1);
`else
    chk("unal_addr", imem_addr, 32'h102);
`endif
    step(1, 0, 0, 32'h0, 1);
`ifdef MISALIGN_CHECK_EN
    chk("mis_clear", {31'b0, inst_misaligned}, 32'h0);
`endif

    // Branch and load together while memory is busy, then reset mid-wait
    Load_hazard = 1; Branch_hazard = 1; branch_target_exe = 32'h500; imem_ready = 0;
    #1;
    chk("both_flush_ex", {31'b0, flush_ex}, 32'h1);
    @(posedge clk);
    #1;
    chk("both_valid", {31'b0, valid_id}, 32'h0);
`ifdef MISALIGN_CHECK_EN
    chk("both_addr", imem_addr, 32'h104);
`else
    chk("both_addr", imem_addr, 32'h106);
`endif
    step(0, 0, 0, 32'h0, 1);
    chk("rst2_addr", imem_addr, 32'h0);
    chk("rst2_valid", {31'b0, valid_id}, 32'h0);
    step(1, 0, 0, 32'h0, 1);
    chk("rst2_run_addr", imem_addr, 32'h4);
    chk("rst2_pc_id", pc_id, 32'h0);
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
